// File: rtl/uart_rx_param_driver.sv
// Parametrised oversampling UART receiver: majority-voted bits, framing/parity tagging, FWFT output FIFO
// with sticky overrun. Define UART_RX_BREAK_DETECT_EN to turn all-zero frames into a brk pulse.
module uart_rx_param_driver #(
    parameter int CYCLES_PER_BIT = 10,
    parameter int DATA_BITS      = 8,
    parameter int PARITY         = 0,
    parameter int STOP_BITS      = 1,
    parameter int FIFO_DEPTH     = 4
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 rxd,
    input  logic                 rd_en,
    input  logic                 clear_overrun,
    output logic [DATA_BITS-1:0] out_data,
    output logic                 out_frame_err,
    output logic                 out_parity_err,
    output logic                 out_valid,
    output logic                 overrun,
    output logic                 brk
);
    localparam int   M       = CYCLES_PER_BIT / 2;
    localparam int   CW      = $clog2(CYCLES_PER_BIT);
    localparam int   BW      = $clog2(DATA_BITS + 1);
    localparam int   AW      = $clog2(FIFO_DEPTH);
    localparam int   EW      = DATA_BITS + 2;
    localparam logic PAR_REQ = (PARITY == 1);

    typedef enum logic [2:0] {
        S_IDLE, S_START, S_DATA, S_PARITY, S_STOP, S_WAIT_HIGH
    } state_t;

    logic                 rx_meta, rxs;
    state_t               state, state_next;
    logic [CW-1:0]        cnt;
    logic [BW-1:0]        bit_idx;
    logic                 s0, s1;
    logic [DATA_BITS-1:0] shreg;
    logic                 frame_err, par_err;
    logic                 at_m1, at_m, at_vote, at_end, maj;
    logic                 last_data, last_stop, frame_err_next;
    logic                 push, brk_pulse, break_frame;

    always_ff @(posedge clk) begin
        if (reset) begin
            rx_meta <= 1'b1;
            rxs     <= 1'b1;
        end else begin
            rx_meta <= rxd;
            rxs     <= rx_meta;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) state <= S_IDLE;
        else       state <= state_next;
    end

    // The third vote is the live rxs at M+1, so every bit decision lands on that cycle.
    always_comb begin
        at_m1          = (cnt == CW'(M - 1));
        at_m           = (cnt == CW'(M));
        at_vote        = (cnt == CW'(M + 1));
        at_end         = (cnt == CW'(CYCLES_PER_BIT - 1));
        maj            = (s0 & s1) | (s0 & rxs) | (s1 & rxs);
        last_data      = (bit_idx == BW'(DATA_BITS - 1));
        last_stop      = (bit_idx == BW'(STOP_BITS - 1));
        frame_err_next = frame_err | ~maj;
        state_next     = state;
        push           = 1'b0;
        brk_pulse      = 1'b0;
        case (state)
            S_IDLE: if (!rxs) state_next = S_START;
            S_START: begin
                if (at_vote && maj) state_next = S_IDLE;
                else if (at_end)    state_next = S_DATA;
            end
            S_DATA: if (at_end && last_data) state_next = (PARITY != 0) ? S_PARITY : S_STOP;
            S_PARITY: if (at_end) state_next = S_STOP;
            S_STOP: begin
                if (at_vote && last_stop) begin
                    if (break_frame) begin
                        brk_pulse  = 1'b1;
                        state_next = S_WAIT_HIGH;
                    end else begin
                        push       = 1'b1;
                        state_next = frame_err_next ? S_WAIT_HIGH : S_IDLE;
                    end
                end
            end
            S_WAIT_HIGH: if (rxs) state_next = S_IDLE;
            default: state_next = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            cnt       <= '0;
            bit_idx   <= '0;
            s0        <= 1'b0;
            s1        <= 1'b0;
            shreg     <= '0;
            frame_err <= 1'b0;
            par_err   <= 1'b0;
        end else begin
            // The first low cycle seen in IDLE counts as cycle 0 of the start bit.
            if (state_next == S_IDLE || state_next == S_WAIT_HIGH) cnt <= '0;
            else if (state == S_IDLE)                             cnt <= CW'(1);
            else if (at_end)                                      cnt <= '0;
            else                                                  cnt <= cnt + 1'b1;
            if (at_m1) s0 <= rxs;
            if (at_m)  s1 <= rxs;
            case (state)
                S_IDLE: begin
                    frame_err <= 1'b0;
                    par_err   <= 1'b0;
                    bit_idx   <= '0;
                end
                S_DATA: begin
                    if (at_vote) shreg <= {maj, shreg[DATA_BITS-1:1]};
                    if (at_end)  bit_idx <= last_data ? '0 : bit_idx + 1'b1;
                end
                S_PARITY: if (at_vote) par_err <= (((^shreg) ^ maj) != PAR_REQ);
                S_STOP: begin
                    if (at_vote) frame_err <= frame_err_next;
                    if (at_end)  bit_idx <= bit_idx + 1'b1;
                end
                default: ;
            endcase
        end
    end

`ifdef UART_RX_BREAK_DETECT_EN
    logic seen_one;
    always_ff @(posedge clk) begin
        if (reset || state == S_IDLE)                       seen_one <= 1'b0;
        else if (at_vote && maj && state != S_WAIT_HIGH)    seen_one <= 1'b1;
    end
    assign break_frame = !seen_one && !maj;
`else
    assign break_frame = 1'b0;
`endif
    assign brk = brk_pulse;

    // Output handshake: an entry leaves the FIFO on every cycle with out_valid=1 and rd_en=1;
    // rd_en while out_valid=0 is ignored.
    logic [EW-1:0] mem [FIFO_DEPTH];
    logic [AW:0]   wr_ptr, rd_ptr;
    logic [EW-1:0] head;
    logic          empty, full, pop, wr;

    assign empty = (wr_ptr == rd_ptr);
    assign full  = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
    assign pop   = rd_en && !empty;
    assign wr    = push && (!full || pop);

    always_ff @(posedge clk) begin
        if (!reset && wr) mem[wr_ptr[AW-1:0]] <= {(PARITY != 0) && par_err, frame_err_next, shreg};
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            wr_ptr  <= '0;
            rd_ptr  <= '0;
            overrun <= 1'b0;
        end else begin
            if (wr)  wr_ptr <= wr_ptr + 1'b1;
            if (pop) rd_ptr <= rd_ptr + 1'b1;
            // A fresh drop wins over a simultaneous clear.
            if (push && full && !pop) overrun <= 1'b1;
            else if (clear_overrun)   overrun <= 1'b0;
        end
    end

    assign head           = mem[rd_ptr[AW-1:0]];
    assign out_valid      = !empty;
    assign out_data       = empty ? '0 : head[DATA_BITS-1:0];
    assign out_frame_err  = !empty && head[DATA_BITS];
    assign out_parity_err = !empty && head[DATA_BITS+1];
endmodule
